// File: rtl/rplybs_pwrup_seq_if.sv
// Control/status bundle between the bias power-up sequencer and its surroundings.
interface rplybs_pwrup_seq_if;
    logic       en;
    logic       bias_ok;
    logic       pwrup_n;
    logic       startup;
    logic [5:0] ibp_en;
    logic       ready;
    logic       fault;

    modport master (
        output en, bias_ok,
        input  pwrup_n, startup, ibp_en, ready, fault
    );

    modport slave (
        input  en, bias_ok,
        output pwrup_n, startup, ibp_en, ready, fault
    );
endinterface

// File: rtl/rplybs_pwrup_seq.sv
// Bias power-up sequencer: start-up kick, BIAS_OK settle qualification,
// staged IBP output ramp, and fault handling for the PMOS mirror bank.
module rplybs_pwrup_seq #(
    parameter int unsigned STARTUP_CYC = 16,
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned STEP_CYC    = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    rplybs_pwrup_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_START,
        S_SETTLE,
        S_RAMP,
        S_ON,
        S_FLT
    } state_t;

    localparam logic [15:0] START_LAST   = 16'(STARTUP_CYC - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] STEP_LAST    = 16'(STEP_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic        bias_ok_p0;
    logic        bok_s;
    logic [15:0] phase_cnt;
    logic [15:0] ok_cnt;
    logic [15:0] dwell_cnt;
    logic [5:0]  ramp_mask;
    logic        settle_hit;
    logic        timeout_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Both compare against the count before this edge, so "LAST" means the edge that completes the run.
    assign settle_hit  = bok_s && (ok_cnt >= SETTLE_LAST);
    assign timeout_hit = (dwell_cnt >= TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            bias_ok_p0  <= 1'b0;
            bok_s       <= 1'b0;
            phase_cnt   <= '0;
            ok_cnt      <= '0;
            dwell_cnt   <= '0;
            ramp_mask   <= '0;
            bus.pwrup_n <= 1'b1;
            bus.startup <= 1'b0;
            bus.ibp_en  <= '0;
            bus.ready   <= 1'b0;
            bus.fault   <= 1'b0;
        end else begin
            bias_ok_p0 <= bus.bias_ok;
            bok_s      <= bias_ok_p0;

            // Outputs are a registered decode of the current state, one cycle behind it.
            bus.pwrup_n <= (state == S_OFF) || (state == S_FLT);
            bus.startup <= (state == S_START);
            bus.ibp_en  <= (state == S_RAMP) ? ramp_mask :
                           ((state == S_ON) ? 6'h3f : 6'h00);
            bus.ready   <= (state == S_ON);
            bus.fault   <= (state == S_FLT);

            // Dropping EN is also the only way out of FLT, so one branch covers both.
            if (!bus.en) begin
                state     <= S_OFF;
                phase_cnt <= '0;
                ok_cnt    <= '0;
                dwell_cnt <= '0;
                ramp_mask <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state     <= S_START;
                        phase_cnt <= '0;
                    end
                    S_START: begin
                        if (phase_cnt >= START_LAST) begin
                            state     <= S_SETTLE;
                            phase_cnt <= '0;
                            ok_cnt    <= '0;
                            dwell_cnt <= '0;
                        end else begin
                            phase_cnt <= sat_inc(phase_cnt);
                        end
                    end
                    S_SETTLE: begin
                        if (settle_hit) begin
                            state     <= S_RAMP;
                            ramp_mask <= 6'b000001;
                            phase_cnt <= '0;
                            ok_cnt    <= '0;
                            dwell_cnt <= '0;
                        end else if (timeout_hit) begin
                            state     <= S_FLT;
                            ok_cnt    <= '0;
                            dwell_cnt <= '0;
                        end else begin
                            ok_cnt    <= bok_s ? sat_inc(ok_cnt) : 16'd0;
                            dwell_cnt <= sat_inc(dwell_cnt);
                        end
                    end
                    S_RAMP: begin
                        if (!bok_s) begin
                            state     <= S_FLT;
                            phase_cnt <= '0;
                            ramp_mask <= '0;
                        end else if (phase_cnt >= STEP_LAST) begin
                            phase_cnt <= '0;
                            if (ramp_mask[5]) begin
                                state <= S_ON;
                            end else begin
                                ramp_mask <= {ramp_mask[4:0], 1'b1};
                            end
                        end else begin
                            phase_cnt <= sat_inc(phase_cnt);
                        end
                    end
                    S_ON: begin
                        if (!bok_s) begin
                            state     <= S_FLT;
                            ramp_mask <= '0;
                        end
                    end
                    S_FLT: begin
                        state <= S_FLT;
                    end
                    default: begin
                        state <= S_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rplybs_pwrup_seq.sv
// Bench for rplybs_pwrup_seq: timeline-based reference model compared every cycle,
// directed scenarios with literal timing points, then a randomized soak.
module tb_rplybs_pwrup_seq;

    localparam int STARTUP_CYC = 16;
    localparam int SETTLE_CYC  = 64;
    localparam int STEP_CYC    = 8;
    localparam int TIMEOUT_CYC = 1024;

    localparam int M_OFF    = 0;
    localparam int M_START  = 1;
    localparam int M_SETTLE = 2;
    localparam int M_RAMP   = 3;
    localparam int M_ON     = 4;
    localparam int M_FLT    = 5;

    localparam logic [9:0] OFF_VEC = 10'h200;

    logic clk = 1'b0;
    logic rst;

    rplybs_pwrup_seq_if bus ();

    rplybs_pwrup_seq #(
        .STARTUP_CYC (STARTUP_CYC),
        .SETTLE_CYC  (SETTLE_CYC),
        .STEP_CYC    (STEP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: current phase, cycles spent in it, current good-bias run,
    // and the last two raw BIAS_OK samples (the synchronizer delay).
    int   m_mode = M_OFF;
    int   m_t    = 0;
    int   m_good = 0;
    logic m_h0   = 1'b0;
    logic m_h1   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    endtask

    function automatic logic [9:0] decode(input int mode, input int t);
        int         n;
        logic [5:0] bits;
        case (mode)
            M_OFF:    return 10'h200;
            M_START:  return 10'h100;
            M_SETTLE: return 10'h000;
            M_RAMP: begin
                n = t / STEP_CYC;
                if (n > 5) n = 5;
                bits = 6'((1 << (n + 1)) - 1);
                return {2'b00, bits, 2'b00};
            end
            M_ON:     return 10'h0FE;
            default:  return 10'h201;
        endcase
    endfunction

    task automatic advance(input logic r, input logic e, input logic b);
        logic bs;
        int   g;
        if (r) begin
            m_mode = M_OFF; m_t = 0; m_good = 0; m_h0 = 1'b0; m_h1 = 1'b0;
            return;
        end
        bs   = m_h1;
        m_h1 = m_h0;
        m_h0 = b;
        if (!e) begin
            m_mode = M_OFF; m_t = 0; m_good = 0;
            return;
        end
        case (m_mode)
            M_OFF: begin m_mode = M_START; m_t = 0; end
            M_START: begin
                if (m_t + 1 >= STARTUP_CYC) begin m_mode = M_SETTLE; m_t = 0; m_good = 0; end
                else m_t++;
            end
            M_SETTLE: begin
                g = bs ? m_good + 1 : 0;
                if (g >= SETTLE_CYC) begin m_mode = M_RAMP; m_t = 0; m_good = 0; end
                else if (m_t + 1 >= TIMEOUT_CYC) begin m_mode = M_FLT; m_t = 0; m_good = 0; end
                else begin m_t++; m_good = g; end
            end
            M_RAMP: begin
                if (!bs) begin m_mode = M_FLT; m_t = 0; end
                else if (m_t + 1 >= 6 * STEP_CYC) begin m_mode = M_ON; m_t = 0; end
                else m_t++;
            end
            M_ON: if (!bs) m_mode = M_FLT;
            default: ;
        endcase
    endtask

    task automatic step();
        logic [9:0] exp_v;
        logic [9:0] act_v;
        @(posedge clk);
        exp_v = rst ? OFF_VEC : decode(m_mode, m_t);
        advance(rst, bus.en, bus.bias_ok);
        #1;
        act_v = {bus.pwrup_n, bus.startup, bus.ibp_en, bus.ready, bus.fault};
        check("cycle", 32'(act_v), 32'(exp_v));
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.pwrup_n, bus.startup, bus.ibp_en, bus.ready, bus.fault});
    endfunction

    task automatic go_off();
        bus.en = 1'b0;
        step();
        step();
    endtask

    // EN is sampled at the edge of k=0; literal points follow the nominal timeline.
    task automatic nominal(input string tag);
        bus.en = 1'b1;
        for (int k = 0; k <= 135; k++) begin
            step();
            case (k)
                0:   check({tag, "_pwrup_k0"},    32'(bus.pwrup_n), 32'd1);
                1: begin
                     check({tag, "_pwrup_k1"},    32'(bus.pwrup_n), 32'd0);
                     check({tag, "_startup_k1"},  32'(bus.startup), 32'd1);
                end
                16:  check({tag, "_startup_k16"}, 32'(bus.startup), 32'd1);
                17:  check({tag, "_startup_k17"}, 32'(bus.startup), 32'd0);
                80:  check({tag, "_ibp_k80"},     32'(bus.ibp_en),  32'h00);
                81:  check({tag, "_ibp_k81"},     32'(bus.ibp_en),  32'h01);
                89:  check({tag, "_ibp_k89"},     32'(bus.ibp_en),  32'h03);
                121: check({tag, "_ibp_k121"},    32'(bus.ibp_en),  32'h3f);
                128: check({tag, "_ready_k128"},  32'(bus.ready),   32'd0);
                129: check({tag, "_ready_k129"},  32'(bus.ready),   32'd1);
                default: ;
            endcase
        end
    endtask

    task automatic ramp_to_k99();
        bus.en = 1'b1;
        for (int k = 0; k <= 99; k++) step();
        check("ramp_k99_ibp", 32'(bus.ibp_en), 32'h07);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.bias_ok = 1'b0;
        repeat (3) step();
        check("reset_outputs", outs(), 32'(OFF_VEC));
        rst = 1'b0;
        bus.bias_ok = 1'b1;
        step();
        step();

        nominal("nom");

        // Disable mid-ramp.
        go_off();
        ramp_to_k99();
        bus.en = 1'b0;
        step();
        step();
        check("disable_ramp_off", outs(), 32'(OFF_VEC));

        // Reset mid-ramp, then the nominal timeline again.
        go_off();
        ramp_to_k99();
        rst = 1'b1;
        step();
        check("reset_ramp_off", outs(), 32'(OFF_VEC));
        rst = 1'b0;
        nominal("rst_re");

        // Settle glitch: 40 good synchronized cycles, then 3 low.
        go_off();
        bus.en = 1'b1;
        for (int k = 0; k <= 135; k++) begin
            bus.bias_ok = (k >= 55 && k <= 57) ? 1'b0 : 1'b1;
            step();
            if (k == 123) check("glitch_ibp_k123", 32'(bus.ibp_en), 32'h00);
            if (k == 124) check("glitch_ibp_k124", 32'(bus.ibp_en), 32'h01);
        end

        // Settle timeout with bias held low.
        go_off();
        bus.bias_ok = 1'b0;
        step();
        step();
        bus.en = 1'b1;
        for (int k = 0; k <= 1050; k++) begin
            step();
            if (k == 1040) check("timeout_fault_k1040", 32'(bus.fault), 32'd0);
            if (k == 1041) begin
                check("timeout_fault_k1041", 32'(bus.fault), 32'd1);
                check("timeout_pwrup_k1041", 32'(bus.pwrup_n), 32'd1);
            end
            if (k == 1050) check("timeout_fault_hold", 32'(bus.fault), 32'd1);
        end
        bus.en = 1'b0;
        step();
        step();
        check("timeout_clear", outs(), 32'(OFF_VEC));

        // Loss of bias while ON.
        bus.bias_ok = 1'b1;
        nominal("on");
        bus.bias_ok = 1'b0;
        for (int k = 0; k <= 3; k++) step();
        check("loss_outputs", outs(), 32'h201);

        // Randomized soak.
        go_off();
        for (int i = 0; i < 15000; i++) begin
            rst = ($urandom_range(0, 1999) == 0);
            if (bus.en) begin
                if ($urandom_range(0, 399) == 0) bus.en = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) bus.en = 1'b1;
            end
            if (bus.bias_ok) begin
                if ($urandom_range(0, 249) == 0) bus.bias_ok = 1'b0;
            end else begin
                if ($urandom_range(0, 14) == 0) bus.bias_ok = 1'b1;
            end
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rplybs_pwrup_seq.md
RPLYBS_PWRUP_SEQ -- requirements
Module: rplybs_pwrup_seq

Interface
REQ-001 The block SHALL have parameter STARTUP_CYC, default 16, giving the number of cycles STARTUP is held high.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 64, giving the consecutive synchronized BIAS_OK-high cycles required before the ramp starts.
REQ-003 The block SHALL have parameter STEP_CYC, default 8, giving the cycles between successive IBP_EN bit enables.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, giving the maximum cycles allowed in SETTLE.
REQ-005 Clocking and reset SHALL be one clock with a synchronous, active-high reset.
REQ-006 CLK  in  1  clock; all logic on the rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 EN  in  1  bias enable request, synchronous to CLK.
REQ-009 BIAS_OK  in  1  asynchronous bias-valid flag from the analog comparator.
REQ-010 PWRUP_N  out  1  active-low power-up to the PMOS mirror bank switch devices.
REQ-011 STARTUP  out  1  start-up kick pulse to the bias core.
REQ-012 IBP_EN  out  6  per-output enables for IBP_1U[5:0].
REQ-013 READY  out  1  bias is up and all outputs are enabled.
REQ-014 FAULT  out  1  start-up timeout or loss of bias.

Function
REQ-015 BIAS_OK SHALL pass through a 2-flop synchronizer; the result is BOK_S, and all logic SHALL use only BOK_S.
REQ-016 The FSM SHALL have states OFF, START, SETTLE, RAMP, ON, FLT; all outputs SHALL be registered and SHALL decode from state and counters only.
REQ-017 In OFF: PWRUP_N=1, STARTUP=0, IBP_EN=0, READY=0, FAULT=0; EN=1 SHALL cause OFF->START on the next edge.
REQ-018 In START: PWRUP_N=0 and STARTUP=1 for exactly STARTUP_CYC cycles, then START->SETTLE.
REQ-019 In SETTLE: PWRUP_N=0 and STARTUP=0.
REQ-020 In SETTLE, a consecutive-cycle counter SHALL count BOK_S=1 cycles and SHALL clear whenever BOK_S=0.
REQ-021 In SETTLE, reaching SETTLE_CYC consecutive cycles SHALL cause SETTLE->RAMP.
REQ-022 In SETTLE, a separate dwell counter SHALL cause SETTLE->FLT once TIMEOUT_CYC cycles have elapsed in SETTLE without the settle condition being met.
REQ-023 If settle and timeout complete in the same cycle, settle SHALL win.
REQ-024 On entry to RAMP, IBP_EN[0] SHALL be set.
REQ-025 Each further STEP_CYC cycles, the next higher IBP_EN bit SHALL be set; set bits SHALL stay set.
REQ-026 STEP_CYC cycles after IBP_EN[5] is set, the FSM SHALL go RAMP->ON.
REQ-027 BOK_S=0 during RAMP SHALL cause a transition to FLT.
REQ-028 In ON: READY=1, IBP_EN=6'b111111, PWRUP_N=0; BOK_S=0 SHALL cause ON->FLT on the next edge.
REQ-029 In FLT: PWRUP_N=1, IBP_EN=0, READY=0, FAULT=1; the FSM SHALL leave FLT only to OFF, and only when EN=0.
REQ-030 EN=0 in any state other than FLT SHALL force OFF on the next edge, with priority over all other transitions; all counters SHALL clear.
REQ-031 Counters SHALL be 16 bits wide and SHALL saturate, never wrap.
REQ-032 Parameter values of 0 are illegal; parameters greater than 65535 are illegal.
REQ-033 Latency from EN rising (sampled) to PWRUP_N low SHALL be 1 cycle.
REQ-034 Latency from EN falling (sampled) to PWRUP_N high SHALL be 1 cycle.
REQ-035 Re-asserting EN in the cycle OFF is entered SHALL restart from START on the following edge.

Reset
REQ-036 RST=1 SHALL force state OFF, clear all counters and synchronizer flops, and set PWRUP_N=1, STARTUP=0, IBP_EN=0, READY=0, FAULT=0 on the next edge.
REQ-037 RST SHALL override EN in every state, including RST asserted mid-RAMP.
REQ-038 After RST is released, the block SHALL require a fresh EN sample before leaving OFF.

Verification
REQ-039 Nominal sequence: BIAS_OK held high, defaults, EN rises sampled at cycle 0 -> PWRUP_N=0 from cycle 1; STARTUP=1 in cycles 1..16; RAMP entered at cycle 81; IBP_EN[k] set at cycle 81+8k; READY=1 from cycle 129.
REQ-040 Settle glitch: during SETTLE, BIAS_OK drops for 3 cycles after 40 good cycles -> the settle count restarts and RAMP is entered 64 cycles after BOK_S returns high.
REQ-041 Timeout: BIAS_OK held low -> FAULT=1 and PWRUP_N=1 after 1024 cycles in SETTLE; FAULT stays high while EN=1; EN=0 -> OFF and FAULT=0 on the next edge.
REQ-042 Loss of bias in ON: BIAS_OK falls while READY=1 -> FAULT=1, READY=0, and IBP_EN=0 within 3 cycles (2 synchronizer cycles plus 1 FSM cycle).
REQ-043 Disable mid-RAMP: EN=0 with IBP_EN=6'b000111 -> all outputs at their OFF values on the next edge.
REQ-044 Reset mid-RAMP: RST=1 with IBP_EN=6'b000111 -> all outputs at their OFF values on the next edge; re-enable afterwards repeats the REQ-039 timing exactly.
